// File: rtl/mcu_target_mux.sv
// Routes MCU frames to one of NUM_TARGETS command targets by the leading id byte
// and muxes the chosen target's reply back. Also folds target IRQs and times out stalled frames.
module mcu_target_mux #(
   parameter int NUM_TARGETS = 4,
   parameter int TIMEOUT     = 4096
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_strobe,
   input  logic                     in_start,
   input  logic [7:0]               in_data,
   output logic [7:0]               out_data,
   output logic [NUM_TARGETS-1:0]   tgt_strobe,
   output logic                     tgt_start,
   output logic [7:0]               tgt_data,
   input  logic [8*NUM_TARGETS-1:0] tgt_dout,
   input  logic [NUM_TARGETS-1:0]   tgt_irq,
   output logic                     int_out_n,
   output logic                     frame_active,
   output logic                     timeout_pulse
);

   localparam int          SEL_W    = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, FIRST, FWD, DISCARD} state_t;

   state_t                  state_reg, state_next;
   logic [SEL_W-1:0]        sel_reg, sel_next;
   logic [15:0]             cnt_reg, cnt_next;
   logic [7:0]              out_data_reg, out_data_next;
   logic [NUM_TARGETS-1:0]  tgt_strobe_reg, tgt_strobe_next;
   logic                    tgt_start_reg, tgt_start_next;
   logic [7:0]              tgt_data_reg, tgt_data_next;
   logic                    timeout_pulse_reg, timeout_pulse_next;
   logic [NUM_TARGETS-1:0]  pending_reg;
   logic                    int_out_n_reg;

   logic                    start_strobe;
   logic                    data_strobe;
   logic                    id_valid;
   logic                    in_frame;
   logic                    expire;
   logic                    fwd_now;
   logic [7:0]              irq_summary;
   logic [7:0]              sel_dout;
   logic [7:0]              dout_arr [NUM_TARGETS];

   assign start_strobe = in_strobe & in_start;
   assign data_strobe  = in_strobe & ~in_start;
   assign id_valid     = (in_data < 8'(NUM_TARGETS));
   assign in_frame     = (state_reg == FIRST) || (state_reg == FWD);
   // A strobe landing on the expiry cycle keeps the frame alive.
   assign expire       = (state_reg != IDLE) && !in_strobe && (cnt_reg == CNT_LAST);
   assign fwd_now      = data_strobe && in_frame;

   generate
      for (genvar gi = 0; gi < NUM_TARGETS; gi++) begin : g_tgt
         assign dout_arr[gi]        = tgt_dout[8*gi +: 8];
         assign tgt_strobe_next[gi] = fwd_now && (sel_reg == SEL_W'(gi));
      end
      for (genvar gi = 0; gi < 8; gi++) begin : g_sum
         if (gi < NUM_TARGETS) begin : g_used
            assign irq_summary[gi] = pending_reg[gi];
         end else begin : g_zero
            assign irq_summary[gi] = 1'b0;
         end
      end
   endgenerate

   always_comb begin
      sel_dout = 8'h00;
      for (int i = 0; i < NUM_TARGETS; i++) begin
         if (sel_reg == SEL_W'(i)) sel_dout = dout_arr[i];
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      if (start_strobe) begin
         state_next = id_valid ? FIRST : DISCARD;
      end else if (expire) begin
         state_next = IDLE;
      end else if (data_strobe && (state_reg == FIRST)) begin
         state_next = FWD;
      end
   end

   // Output / datapath next values
   always_comb begin
      sel_next           = sel_reg;
      out_data_next      = out_data_reg;
      tgt_start_next     = 1'b0;
      tgt_data_next      = tgt_data_reg;
      timeout_pulse_next = expire;
      cnt_next           = cnt_reg + 16'd1;

      if (start_strobe) begin
         out_data_next = irq_summary;
         if (id_valid) sel_next = in_data[SEL_W-1:0];
      end else begin
         case (state_reg)
            FIRST, FWD: out_data_next = sel_dout;
            DISCARD:    out_data_next = 8'hFF;
            default:    out_data_next = out_data_reg;
         endcase
      end

      if (fwd_now) begin
         tgt_data_next  = in_data;
         tgt_start_next = (state_reg == FIRST);
      end

      if (in_strobe || (state_reg == IDLE) || expire) cnt_next = 16'd0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sel_reg           <= '0;
         cnt_reg           <= 16'd0;
         out_data_reg      <= 8'h00;
         tgt_strobe_reg    <= '0;
         tgt_start_reg     <= 1'b0;
         tgt_data_reg      <= 8'h00;
         timeout_pulse_reg <= 1'b0;
         pending_reg       <= '0;
         int_out_n_reg     <= 1'b1;
      end else begin
         sel_reg           <= sel_next;
         cnt_reg           <= cnt_next;
         out_data_reg      <= out_data_next;
         tgt_strobe_reg    <= tgt_strobe_next;
         tgt_start_reg     <= tgt_start_next;
         tgt_data_reg      <= tgt_data_next;
         timeout_pulse_reg <= timeout_pulse_next;
         pending_reg       <= tgt_irq;
         int_out_n_reg     <= ~|pending_reg;
      end
   end

   assign out_data      = out_data_reg;
   assign tgt_strobe    = tgt_strobe_reg;
   assign tgt_start     = tgt_start_reg;
   assign tgt_data      = tgt_data_reg;
   assign timeout_pulse = timeout_pulse_reg;
   assign int_out_n     = int_out_n_reg;
   assign frame_active  = in_frame;

endmodule

// File: tb/tb_mcu_target_mux.sv
// Directed bench for mcu_target_mux: forwarding, reply mux, discard, timeout,
// interrupt aggregation, mid-frame restart and reset.
module tb_mcu_target_mux;

   localparam int NT = 4;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_strobe;
   logic          in_start;
   logic [7:0]    in_data;
   logic [7:0]    out_data;
   logic [NT-1:0] tgt_strobe;
   logic          tgt_start;
   logic [7:0]    tgt_data;
   logic [8*NT-1:0] tgt_dout;
   logic [NT-1:0] tgt_irq;
   logic          int_out_n;
   logic          frame_active;
   logic          timeout_pulse;

   int n_cmp = 0;
   int n_err = 0;

   mcu_target_mux #(.NUM_TARGETS(NT), .TIMEOUT(TO)) dut (
      .clk           (clk),
      .reset         (reset),
      .in_strobe     (in_strobe),
      .in_start      (in_start),
      .in_data       (in_data),
      .out_data      (out_data),
      .tgt_strobe    (tgt_strobe),
      .tgt_start     (tgt_start),
      .tgt_data      (tgt_data),
      .tgt_dout      (tgt_dout),
      .tgt_irq       (tgt_irq),
      .int_out_n     (int_out_n),
      .frame_active  (frame_active),
      .timeout_pulse (timeout_pulse)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic start, input logic [7:0] data);
      in_strobe = 1'b1;
      in_start  = start;
      in_data   = data;
      step();
      in_strobe = 1'b0;
      in_start  = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_out_data"},   32'(out_data),      32'h00);
      chk({tag, "_strobe"},     32'(tgt_strobe),    32'h0);
      chk({tag, "_start"},      32'(tgt_start),     32'h0);
      chk({tag, "_data"},       32'(tgt_data),      32'h00);
      chk({tag, "_int_n"},      32'(int_out_n),     32'h1);
      chk({tag, "_active"},     32'(frame_active),  32'h0);
      chk({tag, "_tpulse"},     32'(timeout_pulse), 32'h0);
   endtask

   initial begin
      reset     = 1'b1;
      in_strobe = 1'b0;
      in_start  = 1'b0;
      in_data   = 8'h00;
      tgt_irq   = '0;
      tgt_dout  = {8'hD3, 8'hC2, 8'h42, 8'h5C};
      step(); step(); step();
      chk_reset_state("rst");
      reset = 1'b0;
      step();

      // Target 2 stream
      send(1'b1, 8'h02);
      chk("t2_active", 32'(frame_active), 32'h1);
      chk("t2_id_nostrobe", 32'(tgt_strobe), 32'h0);
      chk("t2_id_out", 32'(out_data), 32'h00);
      send(1'b0, 8'hA1);
      chk("t2_a1_strobe", 32'(tgt_strobe), 32'h4);
      chk("t2_a1_start", 32'(tgt_start), 32'h1);
      chk("t2_a1_data", 32'(tgt_data), 32'hA1);
      chk("t2_reply", 32'(out_data), 32'hC2);
      step();
      chk("t2_gap_strobe", 32'(tgt_strobe), 32'h0);
      chk("t2_gap_start", 32'(tgt_start), 32'h0);
      chk("t2_gap_hold", 32'(tgt_data), 32'hA1);
      send(1'b0, 8'hB2);
      chk("t2_b2_strobe", 32'(tgt_strobe), 32'h4);
      chk("t2_b2_start", 32'(tgt_start), 32'h0);
      chk("t2_b2_data", 32'(tgt_data), 32'hB2);
      send(1'b0, 8'hC3);
      chk("t2_c3_strobe", 32'(tgt_strobe), 32'h4);
      chk("t2_c3_data", 32'(tgt_data), 32'hC3);

      // Reply mux, targets 0 and 1
      send(1'b1, 8'h00);
      send(1'b0, 8'h11);
      chk("t0_reply", 32'(out_data), 32'h5C);
      chk("t0_strobe", 32'(tgt_strobe), 32'h1);
      chk("t0_start", 32'(tgt_start), 32'h1);
      send(1'b1, 8'h01);
      chk("t1_id_out", 32'(out_data), 32'h00);
      step();
      chk("t1_reply", 32'(out_data), 32'h42);

      // Invalid id -> discard
      send(1'b1, 8'h07);
      chk("bad_active", 32'(frame_active), 32'h0);
      chk("bad_id_out", 32'(out_data), 32'h00);
      for (int i = 0; i < 3; i++) begin
         send(1'b0, 8'(8'h20 + i));
         chk("bad_strobe", 32'(tgt_strobe), 32'h0);
         chk("bad_out", 32'(out_data), 32'hFF);
         chk("bad_active2", 32'(frame_active), 32'h0);
      end
      send(1'b1, 8'h01);
      send(1'b0, 8'h5A);
      chk("rec_strobe", 32'(tgt_strobe), 32'h2);
      chk("rec_start", 32'(tgt_start), 32'h1);
      chk("rec_data", 32'(tgt_data), 32'h5A);

      // Timeout abort
      send(1'b1, 8'h03);
      send(1'b0, 8'h77);
      chk("to_strobe", 32'(tgt_strobe), 32'h8);
      for (int i = 0; i < TO - 1; i++) step();
      chk("to_pre_pulse", 32'(timeout_pulse), 32'h0);
      chk("to_pre_active", 32'(frame_active), 32'h1);
      step();
      chk("to_pulse", 32'(timeout_pulse), 32'h1);
      chk("to_idle", 32'(frame_active), 32'h0);
      step();
      chk("to_pulse_end", 32'(timeout_pulse), 32'h0);
      send(1'b0, 8'h99);
      chk("to_no_fwd", 32'(tgt_strobe), 32'h0);
      chk("to_data_hold", 32'(tgt_data), 32'h77);

      // Strobe on the expiry cycle wins
      send(1'b1, 8'h03);
      send(1'b0, 8'h66);
      for (int i = 0; i < TO - 1; i++) step();
      send(1'b0, 8'h55);
      chk("exp_no_pulse", 32'(timeout_pulse), 32'h0);
      chk("exp_strobe", 32'(tgt_strobe), 32'h8);
      chk("exp_data", 32'(tgt_data), 32'h55);
      chk("exp_active", 32'(frame_active), 32'h1);
      step();
      chk("exp_no_pulse2", 32'(timeout_pulse), 32'h0);

      // Interrupt aggregation
      tgt_irq = 4'b1010;
      step();
      chk("irq_lat1", 32'(int_out_n), 32'h1);
      step();
      chk("irq_assert", 32'(int_out_n), 32'h0);
      send(1'b1, 8'h02);
      chk("irq_summary", 32'(out_data), 32'h0A);
      tgt_irq = 4'b0000;
      step();
      chk("irq_drop_lat1", 32'(int_out_n), 32'h0);
      step();
      chk("irq_release", 32'(int_out_n), 32'h1);

      // Mid-frame restart
      send(1'b1, 8'h01);
      send(1'b0, 8'h10);
      send(1'b0, 8'h20);
      chk("mid_fwd_strobe", 32'(tgt_strobe), 32'h2);
      send(1'b1, 8'h00);
      chk("mid_id_nostrobe", 32'(tgt_strobe), 32'h0);
      send(1'b0, 8'h30);
      chk("mid_strobe", 32'(tgt_strobe), 32'h1);
      chk("mid_start", 32'(tgt_start), 32'h1);
      chk("mid_data", 32'(tgt_data), 32'h30);

      // Reset during FWD, with a concurrent strobe and IRQs
      send(1'b0, 8'h40);
      reset     = 1'b1;
      in_strobe = 1'b1;
      in_start  = 1'b0;
      in_data   = 8'h50;
      tgt_irq   = 4'b1111;
      step();
      in_strobe = 1'b0;
      tgt_irq   = '0;
      chk_reset_state("rst_fwd");
      reset = 1'b0;
      step();
      chk("post_rst_int", 32'(int_out_n), 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mcu_target_mux.md
Name: mcu_target_mux

Overview:
- Front-end dispatcher between the MCU byte-stream receiver and the per-function command targets: system control, OSD/video, HID and SD card.
- The first byte of every MCU frame selects a target. All following bytes are forwarded to that target only, with a regenerated start flag.
- The selected target's reply byte is muxed back to the MCU.
- Also aggregates target interrupt requests into the single active-low MCU interrupt line, and aborts stalled frames with an inactivity timeout.

Parameters:
- NUM_TARGETS, 4, number of downstream targets; legal 1..8.
- TIMEOUT, 4096, clk cycles without an in_strobe before an open frame is aborted; legal 2..65535.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- in_strobe  input  1  one-cycle pulse: in_data valid
- in_start  input  1  qualifies in_strobe: byte is first of a frame
- in_data  input  8  byte from MCU
- out_data  output  8  reply byte to MCU
- tgt_strobe  output  NUM_TARGETS  one-hot forwarded strobe
- tgt_start  output  1  first forwarded byte of frame (shared by all targets)
- tgt_data  output  8  forwarded byte (shared by all targets)
- tgt_dout  input  8*NUM_TARGETS  reply bytes; target n on bits [8n+7:8n]
- tgt_irq  input  NUM_TARGETS  level interrupt requests from targets
- int_out_n  output  1  active-low interrupt to MCU
- frame_active  output  1  high while a valid target is selected
- timeout_pulse  output  1  one-cycle pulse when a frame is aborted

Behaviour:
- Reset values: state IDLE; sel=0; out_data=8'h00; tgt_strobe=0; tgt_start=0; tgt_data=8'h00; int_out_n=1; frame_active=0; timeout_pulse=0; timeout counter=0. Reset overrides every other event in the same cycle.
- States: IDLE, FIRST (target selected, no payload byte forwarded yet), FWD, DISCARD.
- Any state, in_strobe&in_start, id = in_data:
  - Frame restarts, including mid-frame; no strobe is forwarded for the id byte.
  - If id < NUM_TARGETS: sel<=id, go to FIRST.
  - Otherwise go to DISCARD.
  - In both cases out_data <= {pending vector zero-extended to 8 bits} (irq summary returned on the next MCU byte).
- FIRST, in_strobe & !in_start: next cycle tgt_strobe[sel]=1, tgt_start=1, tgt_data=in_data; go to FWD.
- FWD, in_strobe & !in_start: next cycle tgt_strobe[sel]=1, tgt_start=0, tgt_data=in_data.
- DISCARD: non-start strobes are ignored; tgt_strobe stays 0; out_data=8'hFF.
- IDLE, in_strobe & !in_start: ignored; out_data unchanged.
- Forwarding latency is exactly 1 cycle from in_strobe. tgt_strobe and tgt_start are single-cycle pulses. tgt_data holds its last value between strobes.
- In FIRST/FWD, out_data <= tgt_dout[sel] every cycle when no start strobe is present, i.e. a 1-cycle registered mux.
- frame_active=1 exactly in FIRST and FWD.
- Timeout counter:
  - Clears on any in_strobe and in IDLE; otherwise increments in FIRST/FWD/DISCARD.
  - When the counter reaches TIMEOUT-1 with no strobe that cycle: next state IDLE, timeout_pulse=1 for one cycle, counter=0.
  - A strobe arriving in the same cycle as expiry wins; no abort.
- Interrupts:
  - pending = tgt_irq registered once.
  - int_out_n = ~|pending, registered: 2 cycles from tgt_irq to int_out_n.
  - No latching; targets hold irq until acknowledged through their own command.
  - Bits >= NUM_TARGETS in the summary are 0.
- tgt_dout for unselected targets is never observed.

Test Plan:
- Select target 2, then send bytes A1, B2, C3 → tgt_strobe=4'b0100 once per byte, 1 cycle after each in_strobe; tgt_start=1 only with A1; tgt_data=A1,B2,C3; frame_active=1 from the id byte on.
- Target 0 with tgt_dout[7:0]=8'h5C: frame {start 00, 11} → out_data=8'h5C one cycle after sel settles. Target 1 with tgt_dout=8'h42 → out_data=8'h42.
- Start with id 8'h07 (NUM_TARGETS=4), then 3 payload bytes → tgt_strobe stays 0, out_data=8'hFF, frame_active=0. A following start with id 1 forwards normally.
- Select target 3, send one byte, then stall for TIMEOUT cycles → timeout_pulse for exactly 1 cycle at count TIMEOUT-1; state IDLE; next non-start byte not forwarded. Repeat with the strobe landing on the expiry cycle → no abort.
- tgt_irq=4'b1010 → int_out_n=0 two cycles later; a start byte returns out_data=8'h0A. Drop irq → int_out_n=1 two cycles later.
- Mid-frame in FWD to target 1: start with id 0 → next payload byte goes to tgt_strobe=4'b0001 with tgt_start=1. Assert reset during FWD → all outputs return to reset values the next cycle.
